// File: rtl/dat_mem_pkg.sv
// ============================================================================
// Module      : dat_mem_pkg
// Description : Shared state encoding and default geometry for dat_mem_p.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dat_mem_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam int c_DEF_DW = 8;
    localparam int c_DEF_AW = 8;

endpackage

`default_nettype wire

// File: rtl/dat_mem_core.sv
// ============================================================================
// Module      : dat_mem_core
// Description : Storage array, one synchronous write port, registered read
//               port with write-first bypass and out-of-range masking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dat_mem_core
    import dat_mem_pkg::*;
#(
    parameter int DW    = c_DEF_DW,
    parameter int AW    = c_DEF_AW,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] dat_out,
    output logic          rd_valid
);

    logic [DW-1:0] r_mem [DEPTH];
    logic          w_wr_ok;
    logic          w_rd_ok;

    // Range checks only exist when the array is smaller than the address space.
    if (DEPTH < (1 << AW)) begin : g_partial
        localparam logic [AW:0] c_DEPTH_EXT = (AW+1)'(DEPTH);
        assign w_wr_ok = ({1'b0, waddr} < c_DEPTH_EXT);
        assign w_rd_ok = ({1'b0, raddr} < c_DEPTH_EXT);
    end else begin : g_full
        assign w_wr_ok = 1'b1;
        assign w_rd_ok = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we && w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_out  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                if (!w_rd_ok) begin
                    dat_out <= '0;
                end else if (we && (waddr == raddr)) begin
                    dat_out <= wdata;
                end else begin
                    dat_out <= r_mem[raddr];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dat_mem_p.sv
// ============================================================================
// Module      : dat_mem_p
// Description : Data memory with registered read, write-first collisions and
//               a hardware INIT_VAL sweep after reset or on clr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dat_mem_p
    import dat_mem_pkg::*;
#(
    parameter int            DW       = c_DEF_DW,
    parameter int            AW       = c_DEF_AW,
    parameter int            DEPTH    = 1 << AW,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] dat_in,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          clr,
    output logic [DW-1:0] dat_out,
    output logic          rd_valid,
    output logic          busy
);

    localparam logic [AW:0] c_LAST = (AW+1)'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nxt;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic          w_re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter is one bit wider than the address so DEPTH == 2**AW ends cleanly.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Sweep owns the write port while initialising; user reads are blocked.
    always_comb begin
        w_we    = wr_en;
        w_waddr = addr;
        w_wdata = dat_in;
        w_re    = rd_en;
        if (r_state == ST_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_cnt[AW-1:0];
            w_wdata = INIT_VAL;
            w_re    = 1'b0;
        end
    end

    assign busy = (r_state == ST_INIT);

    dat_mem_core #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_we),
        .waddr    (w_waddr),
        .wdata    (w_wdata),
        .re       (w_re),
        .raddr    (addr),
        .dat_out  (dat_out),
        .rd_valid (rd_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_dat_mem_p.sv
// ============================================================================
// Module      : tb_dat_mem_p
// Description : Directed self-checking bench for dat_mem_p (full-depth and
//               DEPTH=200 / INIT_VAL=0xFF instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dat_mem_p;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] dat_in;
    logic       wr_en;
    logic       rd_en;
    logic       clr;
    logic [7:0] dat_out;
    logic       rd_valid;
    logic       busy;

    logic       rst_n2;
    logic [7:0] addr2;
    logic [7:0] dat_in2;
    logic       wr_en2;
    logic       rd_en2;
    logic       clr2;
    logic [7:0] dat_out2;
    logic       rd_valid2;
    logic       busy2;

    int n_checks;
    int n_fail;

    dat_mem_p #(
        .DW (8), .AW (8), .DEPTH (256), .INIT_VAL (8'h00)
    ) dut (
        .clk (clk), .rst_n (rst_n), .addr (addr), .dat_in (dat_in),
        .wr_en (wr_en), .rd_en (rd_en), .clr (clr),
        .dat_out (dat_out), .rd_valid (rd_valid), .busy (busy)
    );

    dat_mem_p #(
        .DW (8), .AW (8), .DEPTH (200), .INIT_VAL (8'hFF)
    ) dut2 (
        .clk (clk), .rst_n (rst_n2), .addr (addr2), .dat_in (dat_in2),
        .wr_en (wr_en2), .rd_en (rd_en2), .clr (clr2),
        .dat_out (dat_out2), .rd_valid (rd_valid2), .busy (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd1(input logic [7:0] a, input logic [7:0] exp, input string tag);
        rd_en = 1'b1;
        addr  = a;
        step();
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, dat_out}, {24'd0, exp});
    endtask

    task automatic wr1(input logic [7:0] a, input logic [7:0] d);
        wr_en  = 1'b1;
        addr   = a;
        dat_in = d;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic rd2(input logic [7:0] a, input logic [7:0] exp, input string tag);
        rd_en2 = 1'b1;
        addr2  = a;
        step();
        rd_en2 = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid2}, 32'd1);
        check({tag, "_data"}, {24'd0, dat_out2}, {24'd0, exp});
    endtask

    // Counts edges until busy drops; an expired budget returns the budget value.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int n2;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; addr = '0; dat_in = '0; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        rst_n2 = 1'b0; addr2 = '0; dat_in2 = '0; wr_en2 = 1'b0; rd_en2 = 1'b0; clr2 = 1'b0;

        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_dat_out", {24'd0, dat_out}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);

        // Both instances leave reset together; record when each sweep ends.
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        n  = 0;
        n2 = 0;
        while (busy && n < 400) begin
            step();
            n++;
            if (!busy2 && n2 == 0) n2 = n;
        end
        check("init_len", n, 256);
        check("init_len_d200", n2, 200);

        rd1(8'h00, 8'h00, "init_rd00");
        rd1(8'h7F, 8'h00, "init_rd7f");
        rd1(8'hFF, 8'h00, "init_rdff");
        step();
        check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);

        wr1(8'h10, 8'hA5);
        rd1(8'h10, 8'hA5, "rd10");
        step();
        check("idle_valid", {31'd0, rd_valid}, 32'd0);
        check("idle_hold", {24'd0, dat_out}, 32'hA5);

        wr_en = 1'b1; rd_en = 1'b1; addr = 8'h20; dat_in = 8'h3C;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("coll_valid", {31'd0, rd_valid}, 32'd1);
        check("coll_data", {24'd0, dat_out}, 32'h3C);
        rd1(8'h20, 8'h3C, "coll_stored");

        wr1(8'h05, 8'h55);
        rd1(8'h05, 8'h55, "rd05_pre");
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd1);
        wr_en = 1'b1; rd_en = 1'b1; addr = 8'h05; dat_in = 8'hAA;
        step();
        check("sweep_no_valid", {31'd0, rd_valid}, 32'd0);
        check("sweep_hold", {24'd0, dat_out}, 32'h55);
        count_busy(n);
        wr_en = 1'b0; rd_en = 1'b0;
        check("clr_len", n + 1, 256);
        rd1(8'h05, 8'h00, "rd05_post");
        rd1(8'h10, 8'h00, "rd10_post");

        wr1(8'h40, 8'h77);
        rd1(8'h40, 8'h77, "rd40");
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (100) step();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dat", {24'd0, dat_out}, 32'd0);
        step();
        step();
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
        count_busy(n);
        check("rerun_len", n, 256);

        check("d200_idle", {31'd0, busy2}, 32'd0);
        rd2(8'h10, 8'hFF, "d200_rd10");
        rd2(8'hC7, 8'hFF, "d200_rdc7");
        wr_en2 = 1'b1; addr2 = 8'hC8; dat_in2 = 8'h5A;
        step();
        wr_en2 = 1'b0;
        rd2(8'hC8, 8'h00, "d200_rdc8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
